pipelined_cla_adder: RTL and testbench

Parametrised, three-stage pipelined carry-lookahead adder/subtractor with valid/ready handshaking on both sides. Operands are split into 4-bit groups; stage 1 forms bit generate/propagate, stage 2 resolves group and word carries through a two-level lookahead tree (group G*/P* plus block carries), and stage 3 forms the sum and flags. It is the next-generation datapath adder for the lab ALU and accumulator paths, replacing fixed 4-bit lookahead units with a registered, width-scalable one.

---
 rtl/pipelined_cla_adder.sv | 166 ++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Three-stage pipelined carry-lookahead adder/subtractor, WIDTH a multiple of 4 (4..64).
// Carries resolve through a 4-bit group -> 4-group block -> word lookahead tree.
module pipelined_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  input  logic             Sub,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             G_star,
  output logic             P_star,
  output logic             OutValid,
  input  logic             OutReady
);

  if (WIDTH < 4 || WIDTH > 64 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of 4 in 4..64");
  end

  localparam int NG = WIDTH / 4;     // 4-bit groups
  localparam int NB = (NG + 3) / 4;  // blocks of four groups (1..4)

  // Handshake: a beat moves on a rising edge where valid and ready are both
  // high; a source holding valid keeps its data stable until that edge. All
  // three stages advance together whenever the output slot is empty or drained.
  logic advance;
  assign advance = !OutValid || OutReady;
  assign InReady = advance;

  // Generate of a 4-wide lookahead cell (carry-in excluded).
  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Carry into position n (0..3) of a 4-wide lookahead cell; n=4 is carry out.
  function automatic logic la_carry(input logic [3:0] g, input logic [3:0] p,
                                    input logic cin, input int unsigned n);
    logic c;
    case (n)
      0:       c = cin;
      1:       c = g[0] | (p[0] & cin);
      2:       c = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      3:       c = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      default: c = grp_gen(g, p) | ((&p) & cin);
    endcase
    return c;
  endfunction

  // Stage 1: effective operands and bit generate/propagate
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] s1_g;
  logic [WIDTH-1:0] s1_p;
  logic             s1_cin;
  logic             s1_valid;

  assign b_eff = Sub ? ~B : B;

  // Stage 2 lookahead tree; unused group/block slots are padded as pass-through
  logic [4*NB-1:0] grp_g;
  logic [4*NB-1:0] grp_p;
  logic [3:0]      blk_g;
  logic [3:0]      blk_p;
  logic [NB-1:0]   blk_cin;
  logic [NG-1:0]   grp_cin;
  logic [WIDTH-1:0] carry;
  logic            word_g;
  logic            word_p;
  logic            word_cout;

  for (genvar j = 0; j < 4 * NB; j++) begin : g_grp
    if (j < NG) begin : g_real
      assign grp_g[j] = grp_gen(s1_g[4*j +: 4], s1_p[4*j +: 4]);
      assign grp_p[j] = &s1_p[4*j +: 4];
    end else begin : g_pad
      assign grp_g[j] = 1'b0;
      assign grp_p[j] = 1'b1;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_blk
    if (k < NB) begin : g_real
      assign blk_g[k] = grp_gen(grp_g[4*k +: 4], grp_p[4*k +: 4]);
      assign blk_p[k] = &grp_p[4*k +: 4];
    end else begin : g_pad
      assign blk_g[k] = 1'b0;
      assign blk_p[k] = 1'b1;
    end
  end

  assign word_g    = grp_gen(blk_g, blk_p);
  assign word_p    = &blk_p;
  assign word_cout = word_g | (word_p & s1_cin);

  for (genvar k = 0; k < NB; k++) begin : g_blk_cin
    assign blk_cin[k] = la_carry(blk_g, blk_p, s1_cin, k);
  end

  for (genvar j = 0; j < NG; j++) begin : g_grp_cin
    assign grp_cin[j] = la_carry(grp_g[4*(j/4) +: 4], grp_p[4*(j/4) +: 4],
                                 blk_cin[j/4], j % 4);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit_c
    assign carry[i] = la_carry(s1_g[4*(i/4) +: 4], s1_p[4*(i/4) +: 4],
                               grp_cin[i/4], i % 4);
  end

  // Stage 2 registers
  logic [WIDTH-1:0] s2_p;
  logic [WIDTH-1:0] s2_c;
  logic             s2_cout;
  logic             s2_g_star;
  logic             s2_p_star;
  logic             s2_valid;

  // Datapath of stages 1-2 carries no reset: only the valid bits qualify it.
  always_ff @(posedge Clk) begin
    if (advance) begin
      s1_g      <= A & b_eff;
      s1_p      <= A ^ b_eff;
      s1_cin    <= Sub | C0;
      s2_p      <= s1_p;
      s2_c      <= carry;
      s2_cout   <= word_cout;
      s2_g_star <= word_g;
      s2_p_star <= word_p;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      OutValid <= 1'b0;
    end else if (advance) begin
      s1_valid <= InValid;
      s2_valid <= s1_valid;
      OutValid <= s2_valid;
    end
  end

  // Stage 3: result registers only reload for a valid beat, so they hold across bubbles
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Sum      <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
      G_star   <= 1'b0;
      P_star   <= 1'b0;
    end else if (advance && s2_valid) begin
      Sum      <= s2_p ^ s2_c;
      Cout     <= s2_cout;
      Overflow <= s2_c[WIDTH-1] ^ s2_cout;
      G_star   <= s2_g_star;
      P_star   <= s2_p_star;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and randomised checks of pipelined_cla_adder at WIDTH 16, 4, 32 and 64,
// with an expected-result queue per instance and an independent arithmetic model.
module tb_pipelined_cla_adder;

  localparam int EW = 68;  // {P*, G*, Overflow, Cout, Sum[63:0]}

  // clock / reset
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  // WIDTH=16 instance (directed tests)
  logic [15:0] a16, b16, sum16;
  logic c0_16, sub16, iv16, ir16, cout16, ovf16, gs16, ps16, ov16, or16;

  // WIDTH=4/32/64 instances share one stimulus stream
  logic [63:0] sw_a, sw_b;
  logic sw_c0, sw_sub, sw_iv, sw_or;
  logic [3:0]  sum4;
  logic [31:0] sum32;
  logic [63:0] sum64;
  logic ir4, cout4, ovf4, gs4, ps4, ov4;
  logic ir32, cout32, ovf32, gs32, ps32, ov32;
  logic ir64, cout64, ovf64, gs64, ps64, ov64;

  pipelined_cla_adder #(.WIDTH(16)) dut16 (
    .Clk(Clk), .Rst(Rst), .A(a16), .B(b16), .C0(c0_16), .Sub(sub16),
    .InValid(iv16), .InReady(ir16), .Sum(sum16), .Cout(cout16), .Overflow(ovf16),
    .G_star(gs16), .P_star(ps16), .OutValid(ov16), .OutReady(or16));

  pipelined_cla_adder #(.WIDTH(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .A(sw_a[3:0]), .B(sw_b[3:0]), .C0(sw_c0), .Sub(sw_sub),
    .InValid(sw_iv), .InReady(ir4), .Sum(sum4), .Cout(cout4), .Overflow(ovf4),
    .G_star(gs4), .P_star(ps4), .OutValid(ov4), .OutReady(sw_or));

  pipelined_cla_adder #(.WIDTH(32)) dut32 (
    .Clk(Clk), .Rst(Rst), .A(sw_a[31:0]), .B(sw_b[31:0]), .C0(sw_c0), .Sub(sw_sub),
    .InValid(sw_iv), .InReady(ir32), .Sum(sum32), .Cout(cout32), .Overflow(ovf32),
    .G_star(gs32), .P_star(ps32), .OutValid(ov32), .OutReady(sw_or));

  pipelined_cla_adder #(.WIDTH(64)) dut64 (
    .Clk(Clk), .Rst(Rst), .A(sw_a), .B(sw_b), .C0(sw_c0), .Sub(sw_sub),
    .InValid(sw_iv), .InReady(ir64), .Sum(sum64), .Cout(cout64), .Overflow(ovf64),
    .G_star(gs64), .P_star(ps64), .OutValid(ov64), .OutReady(sw_or));

  // scoreboard
  logic [EW-1:0] exp_q16[$];
  logic [EW-1:0] exp_q4[$];
  logic [EW-1:0] exp_q32[$];
  logic [EW-1:0] exp_q64[$];
  int n_vec;
  int n_fail;
  logic acc_in, acc_out;

  function automatic logic [EW-1:0] pack(input logic [63:0] s, input logic co,
                                         input logic ov, input logic g, input logic p);
    return {p, g, ov, co, s};
  endfunction

  // Reference: plain wide arithmetic, signed-overflow rule, separate G*/P* sums
  function automatic logic [EW-1:0] model(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input logic c0,
                                          input logic sub);
    logic [63:0] mask, am, bm, s;
    logic [64:0] full, gen;
    logic cin, co, ov, gs, ps;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bm   = (sub ? ~b : b) & mask;
    cin  = sub ? 1'b1 : c0;
    full = {1'b0, am} + {1'b0, bm} + {64'b0, cin};
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    gen  = {1'b0, am} + {1'b0, bm};
    gs   = gen[w];
    ps   = ((am ^ bm) == mask);
    return pack(s, co, ov, gs, ps);
  endfunction

  function automatic logic [EW-1:0] obs16();
    return pack({48'b0, sum16}, cout16, ovf16, gs16, ps16);
  endfunction

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nonempty(input string tag, input int sz);
    n_vec++;
    assert (sz != 0) else begin
      n_fail++;
      $error("FAIL %s: output beat with %0d queued results, required at least 1", tag, sz);
    end
  endtask

  // driver: one cycle on the 16-bit instance; score output/input transfers of the coming edge
  task automatic step16(input logic iv, input logic [15:0] a, input logic [15:0] b,
                        input logic c0, input logic sub, input logic ordy,
                        input logic [EW-1:0] exp);
    @(negedge Clk);
    iv16 = iv; a16 = a; b16 = b; c0_16 = c0; sub16 = sub; or16 = ordy;
    #1;
    acc_out = ov16 && or16;
    acc_in  = iv16 && ir16;
    if (acc_out) begin
      nonempty("q16", exp_q16.size());
      if (exp_q16.size() != 0) check("out16", obs16(), exp_q16.pop_front());
    end
    if (acc_in) exp_q16.push_back(exp);
  endtask

  task automatic idle16();
    step16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic wait_out16(output int lat);
    lat = 0;
    do begin
      idle16();
      lat++;
    end while (!acc_out && lat < 20);
  endtask

  task automatic drain16(input string tag);
    int n = 0;
    while (exp_q16.size() != 0 && n < 50) begin
      idle16();
      n++;
    end
    check(tag, EW'(exp_q16.size()), EW'(0));
  endtask

  // driver: one cycle on the 4/32/64-bit instances in lockstep
  task automatic step_sw(input logic iv, input logic [63:0] a, input logic [63:0] b,
                         input logic c0, input logic sub, input logic ordy);
    @(negedge Clk);
    sw_iv = iv; sw_a = a; sw_b = b; sw_c0 = c0; sw_sub = sub; sw_or = ordy;
    #1;
    acc_in = sw_iv && ir4;
    if (ov4 && sw_or) begin
      nonempty("q4", exp_q4.size());
      if (exp_q4.size() != 0)
        check("out4", pack({60'b0, sum4}, cout4, ovf4, gs4, ps4), exp_q4.pop_front());
    end
    if (ov32 && sw_or) begin
      nonempty("q32", exp_q32.size());
      if (exp_q32.size() != 0)
        check("out32", pack({32'b0, sum32}, cout32, ovf32, gs32, ps32), exp_q32.pop_front());
    end
    if (ov64 && sw_or) begin
      nonempty("q64", exp_q64.size());
      if (exp_q64.size() != 0)
        check("out64", pack(sum64, cout64, ovf64, gs64, ps64), exp_q64.pop_front());
    end
    if (sw_iv && ir4)  exp_q4.push_back(model(4, a, b, c0, sub));
    if (sw_iv && ir32) exp_q32.push_back(model(32, a, b, c0, sub));
    if (sw_iv && ir64) exp_q64.push_back(model(64, a, b, c0, sub));
  endtask

  int lat, st, i_op, sent, cyc;
  logic hold, riv, ro, rc0, rsub;
  logic [63:0] ra, rb;
  logic [EW-1:0] snap;

  initial begin
    n_vec = 0; n_fail = 0;
    acc_in = 1'b0; acc_out = 1'b0;
    Rst = 1'b1;
    a16 = '0; b16 = '0; c0_16 = 1'b0; sub16 = 1'b0; iv16 = 1'b0; or16 = 1'b1;
    sw_a = '0; sw_b = '0; sw_c0 = 1'b0; sw_sub = 1'b0; sw_iv = 1'b0; sw_or = 1'b1;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    #1;
    check("rst_out16", obs16(), '0);
    check("rst_valid16", EW'(ov16), EW'(0));
    check("rst_inready16", EW'(ir16), EW'(1));
    check("rst_out64", pack(sum64, cout64, ovf64, gs64, ps64), '0);
    check("rst_valid64", EW'(ov64), EW'(0));

    // single op: latency and carry ripple through every group
    step16(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, pack(64'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
    check("accept_v1", EW'(acc_in), EW'(1));
    wait_out16(lat);
    check("latency_v1", EW'(lat), EW'(3));

    // subtract and full-propagate vectors back to back
    step16(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, pack(64'h7FFF, 1'b1, 1'b1, 1'b1, 1'b0));
    step16(1'b1, 16'h0003, 16'h0005, 1'b1, 1'b1, 1'b1, pack(64'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0));
    step16(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b1, pack(64'h0000, 1'b1, 1'b0, 1'b0, 1'b1));
    step16(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b1, pack(64'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1));
    drain16("drain_directed");

    // outputs keep the last result while bubbles pass
    idle16();
    idle16();
    check("bubble_hold", obs16(), pack(64'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1));
    check("bubble_valid", EW'(ov16), EW'(0));

    // stream i=1..8 with a 4-cycle output stall
    i_op = 1;
    st = 0;
    snap = '0;
    while ((i_op <= 8 || exp_q16.size() != 0) && st < 60) begin
      step16(i_op <= 8, 16'(i_op), 16'(2 * i_op), 1'b0, 1'b0, !(st >= 5 && st <= 8),
             model(16, 64'(i_op), 64'(2 * i_op), 1'b0, 1'b0));
      if (acc_in) i_op++;
      if (st == 5) snap = obs16();
      if (st >= 5 && st <= 8) begin
        check("stall_inready", EW'(ir16), EW'(0));
        check("stall_valid", EW'(ov16), EW'(1));
      end
      if (st >= 6 && st <= 8) check("stall_hold", obs16(), snap);
      st++;
    end
    check("stall_snapshot", snap, pack(64'd9, 1'b0, 1'b0, 1'b0, 1'b0));
    check("stream_sent", EW'(i_op), EW'(9));
    check("stream_cycles", EW'(st), EW'(15));

    // reset with two ops in flight
    step16(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1, model(16, 64'h1234, 64'h1111, 1'b0, 1'b0));
    step16(1'b1, 16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b1, model(16, 64'h0F0F, 64'h0101, 1'b0, 1'b0));
    @(negedge Clk);
    Rst = 1'b1;
    iv16 = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    exp_q16.delete();
    #1;
    for (int k = 0; k < 4; k++) begin
      check("rst_flush_out", obs16(), '0);
      check("rst_flush_valid", EW'(ov16), EW'(0));
      idle16();
    end
    step16(1'b1, 16'h0021, 16'h0013, 1'b0, 1'b0, 1'b1, pack(64'h0034, 1'b0, 1'b0, 1'b0, 1'b0));
    wait_out16(lat);
    check("latency_after_rst", EW'(lat), EW'(3));

    // random sweep at WIDTH 4/32/64 with random handshakes
    hold = 1'b0; sent = 0; cyc = 0;
    riv = 1'b0; ra = '0; rb = '0; rc0 = 1'b0; rsub = 1'b0;
    while ((sent < 1000 || exp_q4.size() != 0 || exp_q32.size() != 0 || exp_q64.size() != 0)
           && cyc < 20000) begin
      if (!hold) begin
        ra   = ($urandom_range(0, 7) == 0) ? '1 : {$urandom(), $urandom()};
        rb   = ($urandom_range(0, 7) == 0) ? '0 : {$urandom(), $urandom()};
        rc0  = 1'($urandom_range(0, 1));
        rsub = 1'($urandom_range(0, 1));
        riv  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      end
      ro = ($urandom_range(0, 3) != 0);
      step_sw(riv, ra, rb, rc0, rsub, ro);
      if (acc_in) sent++;
      hold = riv && !acc_in;
      cyc++;
    end
    check("sweep_sent", EW'(sent), EW'(1000));
    check("sweep_q4_empty", EW'(exp_q4.size()), EW'(0));
    check("sweep_q32_empty", EW'(exp_q32.size()), EW'(0));
    check("sweep_q64_empty", EW'(exp_q64.size()), EW'(0));

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
